// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle between the cache line port, the burst adaptor and word memory.
// master: the adaptor's view (drives the word request and the line response).
// slave:  the environment's view (the cache plus the physical memory).
interface cacheline_burst_adaptor_if #(
    parameter int LINE_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] line_address;
    logic                  line_read;
    logic                  line_write;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_resp;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        input  line_address, line_read, line_write, line_wdata, mem_rdata, mem_resp,
        output line_rdata, line_resp, mem_address, mem_read, mem_write, mem_wdata
    );

    modport slave (
        output line_address, line_read, line_write, line_wdata, mem_rdata, mem_resp,
        input  line_rdata, line_resp, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits cache line reads/writebacks into sequential word accesses to memory
// and reassembles fills; one line_resp pulse per completed line transaction.
// All outputs are registered; a GAP cycle separates consecutive word requests.
module cacheline_burst_adaptor #(
    parameter int LINE_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic MEM_CLK,
    input logic rst,
    cacheline_burst_adaptor_if.master bus
);
    localparam int BEATS          = LINE_WIDTH / WORD_WIDTH;
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int LINE_BYTES     = LINE_WIDTH / 8;
    localparam int BW             = $clog2(BEATS);
    localparam int WB             = $clog2(BYTES_PER_WORD);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, GAP, DONE} state_t;

    state_t                             state;
    logic [BW-1:0]                      beat;
    logic [ADDR_WIDTH-1:0]              base;
    logic                               op_wr;
    logic [BEATS-1:0][WORD_WIDTH-1:0]   wbuf;
    logic [BEATS-1:0][WORD_WIDTH-1:0]   rbuf;
    logic [BEATS-1:0][WORD_WIDTH-1:0]   rbuf_next;
    logic [ADDR_WIDTH-1:0]              aligned;

    // Line-aligned request address; offset bits inside the line are cleared.
    assign aligned = bus.line_address & ~ADDR_WIDTH'(LINE_BYTES - 1);

    // Read buffer with the current word merged in, so the last beat can
    // publish the complete line in the same edge that raises line_resp.
    always_comb begin
        rbuf_next       = rbuf;
        rbuf_next[beat] = bus.mem_rdata;
    end

    // Main FSM: accept in IDLE, one word per RD/WR, GAP between words, DONE pulse.
    always_ff @(posedge MEM_CLK or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            beat            <= '0;
            base            <= '0;
            op_wr           <= 1'b0;
            wbuf            <= '0;
            rbuf            <= '0;
            bus.line_rdata  <= '0;
            bus.line_resp   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.line_write) begin
                        base            <= aligned;
                        wbuf            <= bus.line_wdata;
                        op_wr           <= 1'b1;
                        beat            <= '0;
                        bus.mem_address <= aligned;
                        bus.mem_wdata   <= bus.line_wdata[WORD_WIDTH-1:0];
                        bus.mem_write   <= 1'b1;
                        state           <= WR;
                    end else if (bus.line_read) begin
                        base            <= aligned;
                        op_wr           <= 1'b0;
                        beat            <= '0;
                        bus.mem_address <= aligned;
                        bus.mem_read    <= 1'b1;
                        state           <= RD;
                    end
                end
                RD: begin
                    if (bus.mem_resp) begin
                        rbuf         <= rbuf_next;
                        bus.mem_read <= 1'b0;
                        if (beat == LAST_BEAT) begin
                            bus.line_rdata <= rbuf_next;
                            bus.line_resp  <= 1'b1;
                            state          <= DONE;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= GAP;
                        end
                    end
                end
                WR: begin
                    if (bus.mem_resp) begin
                        bus.mem_write <= 1'b0;
                        if (beat == LAST_BEAT) begin
                            bus.line_resp <= 1'b1;
                            state         <= DONE;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Address wraps naturally at ADDR_WIDTH bits.
                    bus.mem_address <= base + (ADDR_WIDTH'(beat) << WB);
                    if (op_wr) begin
                        bus.mem_wdata <= wbuf[beat];
                        bus.mem_write <= 1'b1;
                        state         <= WR;
                    end else begin
                        bus.mem_read <= 1'b1;
                        state        <= RD;
                    end
                end
                DONE: begin
                    bus.line_resp <= 1'b0;
                    beat          <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor with a fixed-latency word memory.
module tb_cacheline_burst_adaptor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_burst_adaptor_if bus ();
    cacheline_burst_adaptor dut (.MEM_CLK(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } acc_t;

    acc_t        log_q[$];
    logic [31:0] mem [0:255];
    int unsigned lat = 2;
    int unsigned cnt;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          resp_cnt = 0;
    int          rises    = 0;
    bit          prev_rd  = 1'b0;
    bit          read_seen = 1'b0;
    bit          both_seen = 1'b0;

    // Fixed-latency memory: responds in the lat-th cycle a request is held.
    assign bus.mem_resp  = (bus.mem_read | bus.mem_write) && (cnt == lat - 1);
    assign bus.mem_rdata = (bus.mem_resp && bus.mem_read) ? mem[bus.mem_address[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (bus.mem_read | bus.mem_write) cnt <= bus.mem_resp ? 0 : cnt + 1;
    end

    // Access log, memory writes and bus monitors.
    always @(posedge clk) begin
        if (bus.mem_resp) begin
            log_q.push_back('{bus.mem_address, bus.mem_write ? bus.mem_wdata : bus.mem_rdata, bus.mem_write});
            if (bus.mem_write) mem[bus.mem_address[9:2]] = bus.mem_wdata;
        end
        if (bus.line_resp) resp_cnt++;
        if (bus.mem_read && !prev_rd) rises++;
        prev_rd = bus.mem_read;
        if (bus.mem_read) read_seen = 1'b1;
        if (bus.mem_read && bus.mem_write) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One line transaction; cyc counts the request cycle as 1 up to the line_resp cycle.
    task automatic line_txn(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [255:0] wd, output int cyc);
        @(negedge clk);
        log_q.delete();
        bus.line_address = addr;
        bus.line_wdata   = wd;
        bus.line_read    = rd;
        bus.line_write   = wr;
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.line_resp && cyc < 2000);
        chk("txn_timeout", {255'b0, bus.line_resp}, 256'd1);
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
    endtask

    localparam logic [255:0] LINE2 =
        256'h13034532_89abcdef_76543210_0f1e2d3c_cafef00d_11223344_2468ace0_59191908;

    initial begin
        int cyc;
        int r0;
        logic [255:0] wd3, wd4, exp5;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h59191908; mem[1] = 32'h2468ace0; mem[2] = 32'h11223344; mem[3] = 32'hcafef00d;
        mem[4] = 32'h0f1e2d3c; mem[5] = 32'h76543210; mem[6] = 32'h89abcdef; mem[7] = 32'h13034532;
        for (int k = 0; k < 8; k++) begin
            mem[248 + k]     = 32'hF000_0000 + k;
            exp5[k*32 +: 32] = 32'hF000_0000 + k;
            wd3[k*32 +: 32]  = 32'hAABBCCDD ^ k;
            wd4[k*32 +: 32]  = 32'h0400_0000 + 32'h11 * k;
        end
        bus.line_address = '0; bus.line_wdata = '0; bus.line_read = 1'b0; bus.line_write = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_line_rdata", bus.line_rdata, '0);
        chk("rst_outs", {250'b0, bus.line_resp, bus.mem_read, bus.mem_write, 3'b0}, '0);
        chk("rst_mem_addr", {224'b0, bus.mem_address}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Line read at 0.
        r0 = resp_cnt;
        line_txn(1'b1, 1'b0, 32'h0, '0, cyc);
        chk("rd_line", bus.line_rdata, LINE2);
        chk("rd_cycles", 256'(cyc), 256'd25);
        chk("rd_nbeats", 256'(log_q.size()), 256'd8);
        for (int k = 0; k < 8 && k < log_q.size(); k++)
            chk($sformatf("rd_addr%0d", k), {223'b0, log_q[k].we, log_q[k].addr}, 256'(4 * k));
        repeat (2) @(negedge clk);
        chk("rd_one_resp", 256'(resp_cnt - r0), 256'd1);

        // Reset during RD beat 3.
        lat = 3;
        r0 = resp_cnt;
        @(negedge clk);
        log_q.delete();
        bus.line_address = 32'h0;
        bus.line_read = 1'b1;
        cyc = 0;
        while (!(log_q.size() == 3 && bus.mem_read) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_beat3", 256'(log_q.size()), 256'd3);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {253'b0, bus.line_resp, bus.mem_read, bus.mem_write}, '0);
        chk("midrst_addr", {224'b0, bus.mem_address}, '0);
        chk("midrst_rdata", bus.line_rdata, '0);
        @(negedge clk);
        bus.line_read = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_resp", 256'(resp_cnt - r0), 256'd0);
        chk("midrst_idle", {255'b0, bus.mem_read}, '0);
        lat = 2;

        // Line write at 0x02468C20 and readback.
        r0 = resp_cnt;
        line_txn(1'b0, 1'b1, 32'h0246_8C20, wd3, cyc);
        chk("wr_nbeats", 256'(log_q.size()), 256'd8);
        for (int k = 0; k < 8 && k < log_q.size(); k++)
            chk($sformatf("wr_beat%0d", k), {191'b0, log_q[k].we, log_q[k].addr, log_q[k].data},
                {191'b0, 1'b1, 32'h0246_8C20 + 32'(4 * k), 32'hAABBCCDD ^ 32'(k)});
        chk("wr_rdata_kept", bus.line_rdata, '0);
        line_txn(1'b1, 1'b0, 32'h0246_8C20, '0, cyc);
        chk("wr_readback", bus.line_rdata, wd3);
        repeat (2) @(negedge clk);
        chk("wr_two_resp", 256'(resp_cnt - r0), 256'd2);

        // Both requests high: write wins, no read issued.
        read_seen = 1'b0;
        line_txn(1'b1, 1'b1, 32'h40, wd4, cyc);
        repeat (2) @(negedge clk);
        chk("both_no_read", {255'b0, read_seen}, '0);
        chk("both_nbeats", 256'(log_q.size()), 256'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("both_mem%0d", k), {224'b0, mem[16 + k]}, {224'b0, 32'h0400_0000 + 32'h11 * k});
        chk("both_rdata_kept", bus.line_rdata, wd3);

        // Unaligned address near the top of the address space.
        line_txn(1'b1, 1'b0, 32'hFFFF_FFF4, '0, cyc);
        chk("wrap_nbeats", 256'(log_q.size()), 256'd8);
        if (log_q.size() == 8) begin
            chk("wrap_first", {224'b0, log_q[0].addr}, {224'b0, 32'hFFFF_FFE0});
            chk("wrap_last", {224'b0, log_q[7].addr}, {224'b0, 32'hFFFF_FFFC});
        end
        chk("wrap_line", bus.line_rdata, exp5);

        // Latency: L=1 and L=25, with a request edge per word.
        lat = 1;
        rises = 0;
        line_txn(1'b1, 1'b0, 32'h0, '0, cyc);
        chk("lat1_cycles", 256'(cyc), 256'd17);
        chk("lat1_edges", 256'(rises), 256'd8);
        chk("lat1_line", bus.line_rdata, LINE2);
        lat = 25;
        rises = 0;
        line_txn(1'b1, 1'b0, 32'h0, '0, cyc);
        chk("lat25_cycles", 256'(cyc), 256'd209);
        chk("lat25_edges", 256'(rises), 256'd8);
        chk("never_both", {255'b0, both_seen}, '0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
